// File: rtl/sd_rx_fifo_if.sv
// Bus bundle between the SD receive front end / host side and the RX FIFO.
// Strobe semantics: wr is a one-cycle nibble-valid on wclk (always accepted);
// rd is a one-cycle pop on rclk, honoured only while empty is low.
interface sd_rx_fifo_if #(
  parameter int AW = 4
);
  logic [3:0]    d;
  logic          wr;
  logic          pack_clr;
  logic          rd;
  logic [31:0]   q;
  logic          empty;
  logic          full;
  logic [AW-1:0] mem_used;
  logic          partial;
  logic          overflow;

  modport master (
    output d, wr, pack_clr, rd,
    input  q, empty, full, mem_used, partial, overflow
  );

  modport slave (
    input  d, wr, pack_clr, rd,
    output q, empty, full, mem_used, partial, overflow
  );
endinterface

// File: rtl/sd_rx_fifo.sv
// SD receive FIFO: packs 8 nibbles (first nibble in [31:28]) into 32-bit words
// stored in a circular RAM; the host pops words on rclk with zero read latency.
module sd_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 4
) (
  input  logic         wclk,
  input  logic         rclk,
  input  logic         rst,
  sd_rx_fifo_if.slave  bus
);

  logic [31:0]   shift_q;
  logic [2:0]    ncnt_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic          overflow_q;
  logic [31:0]   ram_q [DEPTH];

  logic [31:0]   word_d;
  logic          take_nib;
  logic          commit;
  logic          empty;
  logic          full;

  assign word_d   = {shift_q[27:0], bus.d};
  assign take_nib = bus.wr && !bus.pack_clr;
  assign commit   = take_nib && (ncnt_q == 3'd7);

  // Both clocks share one source, so the pointers are compared directly.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-2:0] == rptr_q[AW-2:0]) &&
                 (wptr_q[AW-1] != rptr_q[AW-1]);

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      ncnt_q     <= '0;
      wptr_q     <= '0;
      overflow_q <= 1'b0;
    end else if (bus.pack_clr) begin
      shift_q <= '0;
      ncnt_q  <= '0;
    end else if (bus.wr) begin
      shift_q <= word_d;
      ncnt_q  <= ncnt_q + 3'd1;
      if (ncnt_q == 3'd7) begin
        if (!full) wptr_q <= wptr_q + 1'b1;
        else       overflow_q <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge wclk) begin
    if (commit && !full) ram_q[wptr_q[AW-2:0]] <= word_d;
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst)                   rptr_q <= '0;
    else if (bus.rd && !empty) rptr_q <= rptr_q + 1'b1;
  end

  assign bus.q        = ram_q[rptr_q[AW-2:0]];
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.mem_used = wptr_q - rptr_q;
  assign bus.partial  = (ncnt_q != 3'd0);
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_sd_rx_fifo.sv
// Directed bench for sd_rx_fifo with a word scoreboard; inputs change and
// outputs are sampled on the falling edge of the shared clock source.
module tb_sd_rx_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 4;

  logic wclk;
  logic rclk;
  logic rst;

  sd_rx_fifo_if #(.AW(AW)) bus ();

  sd_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .wclk (wclk),
    .rclk (rclk),
    .rst  (rst),
    .bus  (bus)
  );

  // clock / reset
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic [31:0] exp_q[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  logic [31:0] wa, wb, wc, nxt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_flags(input string tag, input logic e, input logic f,
                           input int used, input logic p, input logic o);
    chk({tag, ".empty"},    {31'd0, bus.empty},    {31'd0, e});
    chk({tag, ".full"},     {31'd0, bus.full},     {31'd0, f});
    chk({tag, ".mem_used"}, {28'd0, bus.mem_used}, used);
    chk({tag, ".partial"},  {31'd0, bus.partial},  {31'd0, p});
    chk({tag, ".overflow"}, {31'd0, bus.overflow}, {31'd0, o});
  endtask

  // driver tasks: all start and end just after a falling edge
  task automatic wr_nib(input logic [3:0] n);
    bus.wr = 1'b1;
    bus.d  = n;
    @(negedge wclk);
    bus.wr = 1'b0;
    bus.d  = 4'h0;
  endtask

  task automatic push_word(input logic [31:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    for (int i = 7; i >= 0; i--) wr_nib(w[i*4 +: 4]);
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, ".empty"}, {31'd0, bus.empty}, 32'd1);
    end else begin
      chk(tag, bus.q, exp_q.pop_front());
    end
    bus.rd = 1'b1;
    @(negedge rclk);
    bus.rd = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.d        = 4'h0;
    bus.wr       = 1'b0;
    bus.pack_clr = 1'b0;
    bus.rd       = 1'b0;
    repeat (2) @(negedge wclk);
    rst = 1'b0;
    @(negedge wclk);
    chk_flags("reset", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // pack order
    for (int i = 1; i <= 7; i++) wr_nib(i[3:0]);
    chk("pack7.partial", {31'd0, bus.partial}, 32'd1);
    chk("pack7.empty",   {31'd0, bus.empty},   32'd1);
    exp_q.push_back(32'h12345678);
    wr_nib(4'h8);
    chk("pack8.q", bus.q, 32'h12345678);
    chk_flags("pack8", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    pop_chk("pack8.pop");
    chk("pack8.drained", {31'd0, bus.empty}, 32'd1);

    // fill and overflow
    for (int i = 0; i < 8; i++) push_word(i);
    chk_flags("fill8", 1'b0, 1'b1, 8, 1'b0, 1'b0);
    push_word(32'hDEADBEEF);
    chk_flags("ovf", 1'b0, 1'b1, 8, 1'b0, 1'b1);
    chk("ovf.q", bus.q, 32'h00000000);
    for (int i = 0; i < 8; i++) pop_chk("ovf.pop");
    chk_flags("ovf.drained", 1'b1, 1'b0, 0, 1'b0, 1'b1);
    pop_chk("ovf.rd_empty");
    chk("rd_empty.used", {28'd0, bus.mem_used}, 32'd0);

    // wrap-around
    for (int i = 0; i < 8; i++) push_word($urandom);
    for (int i = 0; i < 8; i++) pop_chk("wrap.pop");
    wa = 32'hAAAA0001; wb = 32'hBBBB0002; wc = 32'hCCCC0003;
    push_word(wa); push_word(wb); push_word(wc);
    chk("wrap.used", {28'd0, bus.mem_used}, 32'd3);
    chk("wrap.full", {31'd0, bus.full}, 32'd0);
    for (int i = 0; i < 3; i++) pop_chk("wrap.abc");

    // simultaneous commit and pop with 4 stored
    for (int i = 0; i < 4; i++) push_word($urandom);
    nxt = $urandom;
    for (int i = 7; i >= 1; i--) wr_nib(nxt[i*4 +: 4]);
    chk("sim.used_before", {28'd0, bus.mem_used}, 32'd4);
    chk("sim.q_before", bus.q, exp_q.pop_front());
    exp_q.push_back(nxt);
    bus.rd = 1'b1;
    wr_nib(nxt[3:0]);
    bus.rd = 1'b0;
    chk("sim.used_after", {28'd0, bus.mem_used}, 32'd4);
    chk("sim.q_after", bus.q, exp_q[0]);
    for (int i = 0; i < 4; i++) pop_chk("sim.drain");

    // commit while full is dropped even with a pop on the same edge
    for (int i = 0; i < 8; i++) push_word($urandom_range(32'hFFFF, 0));
    nxt = 32'h5A5A5A5A;
    for (int i = 7; i >= 1; i--) wr_nib(nxt[i*4 +: 4]);
    chk("full_pop.q_before", bus.q, exp_q.pop_front());
    bus.rd = 1'b1;
    wr_nib(nxt[3:0]);
    bus.rd = 1'b0;
    chk("full_pop.used", {28'd0, bus.mem_used}, 32'd7);
    for (int i = 0; i < 7; i++) pop_chk("full_pop.drain");
    chk("full_pop.empty", {31'd0, bus.empty}, 32'd1);

    // pack_clr discards the partial word
    for (int i = 0; i < 5; i++) wr_nib(4'(i + 9));
    chk("clr.partial_before", {31'd0, bus.partial}, 32'd1);
    bus.pack_clr = 1'b1;
    wr_nib(4'hF);
    bus.pack_clr = 1'b0;
    chk("clr.partial", {31'd0, bus.partial}, 32'd0);
    chk("clr.used", {28'd0, bus.mem_used}, 32'd0);
    push_word(32'h87654321);
    chk("clr.q", bus.q, 32'h87654321);
    pop_chk("clr.pop");

    // asynchronous reset mid-operation
    push_word(32'h11112222);
    push_word(32'h33334444);
    for (int i = 0; i < 3; i++) wr_nib(4'h6);
    chk("rst_mid.partial", {31'd0, bus.partial}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_flags("rst_mid", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    exp_q.delete();
    @(negedge wclk);
    rst = 1'b0;
    @(negedge wclk);
    push_word(32'hCAFEF00D);
    chk("post_rst.q", bus.q, 32'hCAFEF00D);
    chk("post_rst.used", {28'd0, bus.mem_used}, 32'd1);
    for (int i = 0; i < 4; i++) push_word($urandom);
    for (int i = 0; i < 5; i++) pop_chk("post_rst.pop");
    chk_flags("final", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sd_rx_fifo.md
# sd_rx_fifo

Receive-direction data FIFO of the SD controller, the counterpart of the TX FIFO. The SD data-line front end pushes 4-bit nibbles in card bit order on `wclk`. The block packs every 8 nibbles into one 32-bit word and stores it in a circular RAM. The host/bus side pops words on `rclk`, and the block reports occupancy and a sticky overflow flag.

## Interface
- `DEPTH`, 8: number of 32-bit words stored; must be a power of two.
- `AW`, 4: pointer width, log2(`DEPTH`)+1; the MSB is the wrap bit.

- `wclk` in 1: write-side clock (SD data path).
- `rst` in 1: reset, asynchronous, active-high; clears both clock domains.
- `rclk` in 1: read-side clock (host side). It is derived from the same source as `wclk`; no pointer synchronisers are used.
- `d` in 4: received nibble; `d[3]` is the earliest bit on the SD line.
- `wr` in 1: nibble valid, sampled on `wclk`.
- `pack_clr` in 1: synchronous to `wclk`; discards the partial word and sets the nibble count to 0.
- `rd` in 1: pop request, sampled on `rclk`.
- `q` out 32: word at the read pointer (combinational RAM read).
- `empty` out 1: no complete word stored.
- `full` out 1: `DEPTH` words stored.
- `mem_used` out AW: stored word count, 0..`DEPTH`.
- `partial` out 1: nibble count ≠ 0.
- `overflow` out 1: sticky; a completed word was dropped because the FIFO was full.

## Operation
- Packer: a 32-bit shift register plus a 3-bit nibble counter `ncnt`, in the `wclk` domain.
  - On `wr`: shift register <= {shift[27:0], d}; `ncnt` increments.
  - The first nibble therefore ends in bits [31:28].
- Commit: on the `wr` edge where `ncnt`==7, the completed word {shift[27:0], d} is committed.
  - `ncnt` wraps to 0.
  - If not `full`: the word is written to ram[wptr[AW-2:0]] and `wptr` increments.
  - If `full`: the word is dropped, `wptr` holds and `overflow` <= 1.
- Pointer wrap: at index `DEPTH`-1 the low bits go to 0 and the MSB toggles.
  - This applies to both `wptr` and `rptr`.
  - Equivalent to a plain AW-bit increment, since `DEPTH` is a power of two.
- Read: on `rclk`, if `rd` and not `empty`, `rptr` advances. `rd` while `empty` is ignored.
- `pack_clr` has priority over `wr` in the same cycle.
  - The nibble is discarded, `ncnt` <= 0 and no commit occurs.
  - Stored words and `overflow` are unaffected.
- Flags (combinational from the pointers):
  - `empty` = (`wptr` == `rptr`).
  - `full` = low bits equal and MSBs differ.
  - `mem_used` = `wptr` − `rptr`, modulo 2^AW.
- `overflow` clears only on `rst`.
- `partial` = (`ncnt` != 0).

## Timing
- Reset values:
  - `wptr` = `rptr` = 0, `ncnt` = 0, shift register = 0, `overflow` = 0.
  - Outputs: `empty`=1, `full`=0, `mem_used`=0, `partial`=0, `overflow`=0.
  - `q` = ram[0], with undefined contents; RAM is not cleared.
- Reset mid-packing discards the partial word.
  - The first `wr` after `rst` deasserts is nibble 0 of a new word.
- Latency: after the `wclk` edge that takes the 8th nibble, `empty` falls, `mem_used` increments and `q` shows the word in the same cycle (0 cycles of read latency).
- After the `rclk` edge that accepts `rd`, `q` shows the next word combinationally.
- A commit (`wclk`) and a pop (`rclk`) on coincident edges are both performed; `mem_used` is unchanged net.
- A commit is decided by `full` as seen at that `wclk` edge. A pop at the same edge does not rescue the word.
- Every 8th nibble throughput: one word per 8 `wr` cycles at most; `rd` may pop one word per `rclk`.

## Test plan
- Reset: assert `rst` mid-operation.
  - Required: `empty`=1, `full`=0, `mem_used`=0, `partial`=0, `overflow`=0 immediately, without a clock edge.
- Pack order:
  - `wr` with nibbles 1,2,3,4,5,6,7 -> `partial`=1, `empty`=1.
  - 8th nibble 8 -> `q`=32'h12345678, `empty`=0, `mem_used`=1, `partial`=0.
- Full/overflow:
  - Commit 8 words 32'h0000000N (N=0..7) -> `full`=1, `mem_used`=8.
  - 9th word 32'hDEADBEEF -> `overflow`=1, `mem_used`=8, `q`=32'h00000000.
  - Popping all 8 returns 0..7 in order, then `empty`=1.
- Wrap-around:
  - Write 8 words, read 8, then write 3 words A,B,C.
  - Required: `mem_used`=3, `full`=0, and reads return A,B,C with `wptr` MSB toggled.
- Simultaneous: with `mem_used`=4, a commit and `rd` on the same edge -> `mem_used`=4, and the next `q` is the 2nd oldest word.
- `pack_clr`:
  - After 5 nibbles, `pack_clr`=1 together with `wr` -> `partial`=0, `mem_used` unchanged.
  - The next 8 nibbles 8,7,6,5,4,3,2,1 -> `q`=32'h87654321.
